// File: rtl/prog_seq.sv
// Programmable control sequencer: fetches opcodes from an external program
// memory and strobes operand-load / bit-serial multiply / add enables.
module prog_seq #(
  parameter int Psize = 3,
  parameter int Isize = 2,
  parameter int N     = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_sw,
  input  logic [Isize:0]         i_instr,
  output logic [Psize-1:0]       o_pc,
  output logic                   o_load_x,
  output logic                   o_mult_en,
  output logic                   o_mult_sel,
  output logic                   o_add_en,
  output logic [$clog2(N)-1:0]   o_bitcnt,
  output logic                   o_bit_first,
  output logic                   o_bit_last,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int BW = $clog2(N);
  localparam int IW = Isize + 1;

  localparam logic [BW-1:0] BIT_LAST   = BW'(N - 1);
  localparam logic [Isize:0] OP_MULT_YD = IW'(3'b010);
  localparam logic [Isize:0] OP_MULT_X  = IW'(3'b011);
  localparam logic [Isize:0] OP_ADD     = IW'(3'b100);
  localparam logic [Isize:0] OP_WAIT    = IW'(3'b110);
  localparam logic [Isize:0] OP_LOAD_X  = IW'(3'b111);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [Psize-1:0]  pc_q, pc_d;
  logic [Isize:0]    ir_q, ir_d;
  logic [BW-1:0]     bitcnt_q, bitcnt_d;

  logic is_mult;
  logic is_add;
  logic is_serial;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  // Decode uses the latched instruction only, so memory changes during EXEC are harmless.
  always_comb begin
    is_mult   = (ir_q == OP_MULT_YD) || (ir_q == OP_MULT_X);
    is_add    = (ir_q == OP_ADD);
    is_serial = is_mult || is_add;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    bitcnt_d    = '0;
    o_load_x    = 1'b0;
    o_mult_en   = 1'b0;
    o_mult_sel  = 1'b0;
    o_add_en    = 1'b0;
    o_bit_first = 1'b0;
    o_bit_last  = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        pc_d = '0;
        if (i_sw) state_d = S_FETCH;
      end
      S_FETCH: begin
        o_busy  = 1'b1;
        ir_d    = i_instr;
        state_d = (i_instr == OP_WAIT) ? S_WAIT : S_EXEC;
      end
      S_EXEC: begin
        o_busy = 1'b1;
        if (is_serial) begin
          o_mult_en   = is_mult;
          o_mult_sel  = is_mult & ir_q[0];
          o_add_en    = is_add;
          o_bit_first = (bitcnt_q == '0);
          o_bit_last  = (bitcnt_q == BIT_LAST);
          if (bitcnt_q == BIT_LAST) begin
            pc_d    = pc_q + 1'b1;
            state_d = S_FETCH;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end else begin
          o_load_x = (ir_q == OP_LOAD_X);
          pc_d     = pc_q + 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_WAIT: begin
        o_busy = 1'b1;
        o_done = 1'b1;
        if (!i_sw) begin
          pc_d    = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_pc     = pc_q;
  assign o_bitcnt = bitcnt_q;

endmodule

// File: doc/prog_seq.md
PROG_SEQ -- requirements
Module: prog_seq

Interface
REQ-001 Parameter Psize, default 3, program-memory address width.
REQ-002 Parameter Isize, default 2, instruction code is Isize+1 bits wide.
REQ-003 Parameter N, default 8, data word width, which is also the number of cycles per bit-serial operation.
REQ-004 i_clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_sw  input  1  run switch; 1 starts the program, 0 releases the final wait.
REQ-007 i_instr  input  Isize+1  instruction read combinationally from program memory at o_pc.
REQ-008 o_pc  output  Psize  program counter, drives the program-memory address.
REQ-009 o_load_x  output  1  one-cycle strobe that loads operand X.
REQ-010 o_mult_en  output  1  bit-serial multiply active.
REQ-011 o_mult_sel  output  1  multiply operand select: 0 = (y,d), 1 = (x,1-d).
REQ-012 o_add_en  output  1  bit-serial add y,x active.
REQ-013 o_bitcnt  output  $clog2(N)  current bit index of the serial operation.
REQ-014 o_bit_first / o_bit_last  output  1 each  asserted when o_bitcnt==0 / o_bitcnt==N-1 during a serial operation.
REQ-015 o_busy  output  1  high in every state except IDLE.
REQ-016 o_done  output  1  high while waiting for the switch to turn off.

Function
REQ-017 Opcodes: 000 NOP, 001 STALL, 010 MULT y,d, 011 MULT x,1-d, 100 ADD y,x, 101 reserved (executes as NOP), 110 WAIT_SW_OFF, 111 LOAD_X.
REQ-018 The FSM shall have four states: IDLE, FETCH, EXEC, WAIT.
REQ-019 IDLE: o_pc held at 0, all enables 0; i_sw==1 sampled on a clock edge moves the FSM to FETCH.
REQ-020 FETCH: one cycle; the instruction register shall latch i_instr; next state EXEC, except opcode 110, which goes to WAIT.
REQ-021 EXEC for NOP, STALL or reserved: one cycle with no enables asserted; o_pc increments; next state FETCH.
REQ-022 EXEC for LOAD_X: o_load_x=1 for exactly this one cycle; o_pc increments; next state FETCH.
REQ-023 EXEC for MULT/ADD: lasts exactly N cycles with o_bitcnt counting 0..N-1, the matching enable high in every cycle and o_mult_sel set by opcode bit 0; on the cycle with o_bitcnt==N-1, o_pc increments, o_bitcnt returns to 0 and the next state is FETCH.
REQ-024 Control outputs shall be decoded from the state and the instruction register only, never directly from i_instr; o_bitcnt shall be 0 outside serial EXEC.
REQ-025 o_pc shall increment modulo 2^Psize: a non-WAIT instruction at the last address wraps the PC to 0 and execution continues.
REQ-026 WAIT: o_done=1 and o_pc holds; when i_sw==0, the next state is IDLE and o_pc=0.
REQ-027 A low i_sw outside WAIT shall be ignored; the program runs on until WAIT_SW_OFF.
REQ-028 Instruction cost: 2 cycles for single-cycle ops, N+1 cycles for serial ops.

Reset
REQ-029 Asserting i_rst shall, immediately and independently of i_clk, force the state to IDLE and o_pc, the instruction register and o_bitcnt to 0, with every output 0.
REQ-030 Reset asserted mid serial operation shall abort that operation with no further enable cycles; after release the FSM waits in IDLE for i_sw.

Verification
REQ-031 Program 0:NOP 1:LOAD_X 2:STALL 3:MULT y,d 4:STALL 5:MULT x,1-d 6:ADD 7:WAIT, N=8, i_sw=1, first FETCH counted as cycle 0 -> o_load_x high in cycle 3 only; o_mult_en with o_mult_sel=0 in cycles 7-14; o_mult_sel=1 in cycles 18-25; o_add_en in cycles 27-34; o_done rises in cycle 36.
REQ-032 Same run, i_sw dropped to 0 at cycle 40 -> FSM in IDLE one edge later with o_pc=0 and o_busy=0; i_sw=1 again -> program restarts at address 0.
REQ-033 i_rst pulsed asynchronously during cycle 10 (o_bitcnt=3) -> o_mult_en and o_bitcnt drop to 0 before the next clock edge; o_pc=0 and the FSM is in IDLE.
REQ-034 Memory filled with NOPs -> o_pc counts 0..7 then wraps to 0 with 2 cycles per address; o_done never asserted.
REQ-035 Opcode 101 at address 0 -> 2 cycles with no enables asserted, then o_pc=1.
REQ-036 i_sw toggled 1->0->1 during serial MULT -> no effect on sequencing; o_done asserted at the same cycle as in REQ-031.
